// File: rtl/sequence_detector.sv
// Serial pattern detector: flags completion of an N-bit PATTERN (MSB received first)
// with a one-cycle registered pulse on Q. OVERLAP selects whether a match tail may seed the next match.
module sequence_detector #(
    parameter int          N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter bit          OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic Q
);

    localparam int CW = $clog2(N + 1);

    generate
        if (N < 2 || N > 16) begin : g_bad_n
            $error("sequence_detector: N must be in 2..16");
        end
    endgenerate

    // Only the newest N-1 bits are kept; the oldest bit of the window would be shifted out unused.
    logic [N-2:0]  r_hist;
    logic [CW-1:0] r_cnt;
    logic          r_q;

    logic [N-1:0]  w_window;
    logic          w_full;
    logic          w_match;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_window = {r_hist, d};
        // cnt gates the match so reset-cleared zeros never satisfy leading-zero patterns.
        w_full   = (int'(r_cnt) + 1) >= N;
        w_match  = w_full && (w_window == PATTERN);

        w_cnt_next = r_cnt;
        if (!OVERLAP && w_match) begin
            w_cnt_next = '0;
        end else if (int'(r_cnt) < N) begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_cnt  <= '0;
            r_q    <= 1'b0;
        end else begin
            r_hist <= w_window[N-2:0];
            r_cnt  <= w_cnt_next;
            r_q    <= w_match;
        end
    end

    assign Q = r_q;

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector: five parameter variants share one stimulus stream,
// each scenario checks the variant it targets against hand-computed pulse vectors.
module tb_sequence_detector;

    logic clk;
    logic rst;
    logic d;
    logic q_def, q_ov0, q_z, q_one1, q_one0;

    int n_cmp = 0;
    int n_err = 0;

    sequence_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_def (
        .clk(clk), .rst(rst), .d(d), .Q(q_def));
    sequence_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_ov0 (
        .clk(clk), .rst(rst), .d(d), .Q(q_ov0));
    sequence_detector #(.N(4), .PATTERN(4'b0001), .OVERLAP(1'b1)) u_z (
        .clk(clk), .rst(rst), .d(d), .Q(q_z));
    sequence_detector #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1)) u_one1 (
        .clk(clk), .rst(rst), .d(d), .Q(q_one1));
    sequence_detector #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b0)) u_one0 (
        .clk(clk), .rst(rst), .d(d), .Q(q_one0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Holds reset across one edge, checks every variant is cleared, then releases just after the edge.
    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_def", q_def, 1'b0);
        chk("rst_ov0", q_ov0, 1'b0);
        chk("rst_z", q_z, 1'b0);
        chk("rst_one1", q_one1, 1'b0);
        chk("rst_one0", q_one0, 1'b0);
        rst = 1'b1;
    endtask

    // Drives one bit, waits for the sampling edge, returns the Q values seen 1ns later.
    task automatic send(input logic b, input bit glitch,
                        output logic [4:0] qs);
        if (glitch) begin
            d = ~b; #2; d = b; #2; d = ~b; #2; d = b;
        end else begin
            d = b;
        end
        @(posedge clk);
        #1;
        qs = {q_def, q_ov0, q_z, q_one1, q_one0};
    endtask

    // Sends bits[len-1] first; checks the selected variant against exp (exp[len-1] pairs with first bit).
    task automatic run(input string tag, input int sel, input logic [15:0] bits,
                       input logic [15:0] exp, input int len, input bit glitch);
        logic [4:0] qs;
        for (int i = len - 1; i >= 0; i--) begin
            send(bits[i], glitch, qs);
            chk($sformatf("%s_b%0d", tag, len - i), qs[4 - sel], exp[i]);
        end
    endtask

    initial begin
        logic [4:0] qs;
        rst = 1'b0;
        d   = 1'b0;

        // Reset held while clk and d toggle.
        for (int i = 0; i < 2; i++) begin
            #3 d = ~d;
            @(posedge clk);
            #1;
            chk("rst_hold", q_def, 1'b0);
            chk("rst_hold_z", q_z, 1'b0);
        end
        rst = 1'b1;

        // Mid-stream reset after 101: following 1 must not complete 1011.
        run("mid", 0, 16'b101, 16'b000, 3, 1'b0);
        #2 rst = 1'b0;
        #1 chk("mid_async", q_def, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        run("mid_after", 0, 16'b1, 16'b0, 1, 1'b0);

        // Async reset must drop a live pulse immediately.
        do_reset();
        run("pulse", 0, 16'b1011, 16'b0001, 4, 1'b0);
        #2 rst = 1'b0;
        #1 chk("async_drop", q_def, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Default stream: single pulse after the 4th sample.
        do_reset();
        run("dflt", 0, 16'b101101001010, 16'b000100000000, 12, 1'b0);

        // Overlap vs non-overlap on 1011011, then a trailing 1011.
        do_reset();
        d = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            logic [6:0] s, e1, e0;
            s = 7'b1011011; e1 = 7'b0001001; e0 = 7'b0001000;
            send(s[i], 1'b0, qs);
            chk($sformatf("ov1_b%0d", 7 - i), qs[4], e1[i]);
            chk($sformatf("ov0_b%0d", 7 - i), qs[3], e0[i]);
        end
        run("ov0_tail", 1, 16'b1011, 16'b0001, 4, 1'b0);

        // Leading-zero pattern: early 001 is below fill count.
        do_reset();
        run("lz_short", 2, 16'b001, 16'b000, 3, 1'b0);
        do_reset();
        run("lz_full", 2, 16'b0001, 16'b0001, 4, 1'b0);

        // Back-to-back all-ones pattern.
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            logic [5:0] e1, e0;
            e1 = 6'b000111; e0 = 6'b000100;
            send(1'b1, 1'b0, qs);
            chk($sformatf("b2b1_b%0d", 6 - i), qs[1], e1[i]);
            chk($sformatf("b2b0_b%0d", 6 - i), qs[0], e0[i]);
        end

        // Glitches between edges must be ignored.
        do_reset();
        run("glitch", 0, 16'b1011, 16'b0001, 4, 1'b1);
        run("glitch_tail", 0, 16'b0, 16'b0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
